// File: rtl/volatility_feed.sv
// Top-of-book front end: keeps per-stock best bid/ask, coalesces bursts and issues
// paced round-robin updates. Define VOLFEED_STATS_EN to add the o_coalesce_count port.
module volatility_feed #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STOCKS = 4,
  parameter int ISSUE_GAP  = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
  input  logic                          i_data_valid,
  input  logic                          i_side,
  input  logic [DATA_WIDTH-1:0]         i_price,
  output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
  output logic [DATA_WIDTH-1:0]         o_best_ask,
  output logic [DATA_WIDTH-1:0]         o_best_bid,
  output logic                          o_data_valid,
`ifdef VOLFEED_STATS_EN
  output logic [31:0]                   o_coalesce_count,
`endif
  output logic [NUM_STOCKS-1:0]         o_pending
);
  localparam int SW = $clog2(NUM_STOCKS);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [3:0] GAP_LAST = 4'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);

  logic [DATA_WIDTH-1:0] r_bid [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] r_ask [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] r_bid_seen, r_ask_seen, r_pending;
  logic [SW-1:0]         r_ptr;
  logic [1:0]            r_state;
  logic [3:0]            r_gap_cnt;
  logic [SW-1:0]         r_stock_id;
  logic [DATA_WIDTH-1:0] r_best_ask, r_best_bid;
  logic                  r_data_valid;

  logic [SW-1:0]         w_cand, w_idx;
  logic                  w_slot, w_issue, w_book_ok;
  logic [DATA_WIDTH-1:0] w_new_bid, w_new_ask;
  logic [NUM_STOCKS-1:0] w_pend_nxt;

  // Rotating priority: lowest offset from r_ptr wins, so scan offsets high to low.
  always_comb begin
    w_cand = r_ptr;
    w_idx  = r_ptr;
    for (int i = NUM_STOCKS - 1; i >= 0; i--) begin
      w_idx = r_ptr + SW'(i);
      if (r_pending[w_idx]) w_cand = w_idx;
    end
  end

  always_comb begin
    case (r_state)
      S_IDLE:  w_slot = 1'b1;
      S_ISSUE: w_slot = (ISSUE_GAP == 0);
      S_GAP:   w_slot = (r_gap_cnt == GAP_LAST);
      default: w_slot = 1'b1;
    endcase
    w_issue = w_slot && (|r_pending);
  end

  // Book validity is judged on the values as they will be after this write.
  always_comb begin
    w_new_bid = i_side ? r_bid[i_stock_id] : i_price;
    w_new_ask = i_side ? i_price : r_ask[i_stock_id];
    w_book_ok = (i_side ? r_bid_seen[i_stock_id] : 1'b1) &&
                (i_side ? 1'b1 : r_ask_seen[i_stock_id]) &&
                (w_new_bid < w_new_ask);
    w_pend_nxt = r_pending;
    if (w_issue) w_pend_nxt[w_cand] = 1'b0;
    if (i_data_valid && w_book_ok) w_pend_nxt[i_stock_id] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        r_bid[s] <= '0;
        r_ask[s] <= '0;
      end
      r_bid_seen   <= '0;
      r_ask_seen   <= '0;
      r_pending    <= '0;
      r_ptr        <= '0;
      r_state      <= S_IDLE;
      r_gap_cnt    <= '0;
      r_stock_id   <= '0;
      r_best_ask   <= '0;
      r_best_bid   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      if (i_data_valid) begin
        if (i_side) begin
          r_ask[i_stock_id]      <= i_price;
          r_ask_seen[i_stock_id] <= 1'b1;
        end else begin
          r_bid[i_stock_id]      <= i_price;
          r_bid_seen[i_stock_id] <= 1'b1;
        end
      end
      r_pending    <= w_pend_nxt;
      r_data_valid <= w_issue;
      if (w_issue) begin
        r_stock_id <= w_cand;
        r_best_ask <= r_ask[w_cand];
        r_best_bid <= r_bid[w_cand];
        r_ptr      <= w_cand + 1'b1;
        r_state    <= S_ISSUE;
      end else if (r_state == S_ISSUE && ISSUE_GAP > 0) begin
        r_state   <= S_GAP;
        r_gap_cnt <= '0;
      end else if (r_state == S_GAP && r_gap_cnt != GAP_LAST) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

`ifdef VOLFEED_STATS_EN
  logic [31:0] r_coalesce_count;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_coalesce_count <= '0;
    else if (i_data_valid && w_book_ok && r_pending[i_stock_id] &&
             !(w_issue && w_cand == i_stock_id) && r_coalesce_count != '1)
      r_coalesce_count <= r_coalesce_count + 1'b1;
  end
  assign o_coalesce_count = r_coalesce_count;
`endif

  assign o_stock_id   = r_stock_id;
  assign o_best_ask   = r_best_ask;
  assign o_best_bid   = r_best_bid;
  assign o_data_valid = r_data_valid;
  assign o_pending    = r_pending;
endmodule

// File: doc/volatility_feed.md
Name: volatility_feed

Overview:
- Producer-side front end of the volatility block.
- Accepts single-sided top-of-book price updates per stock and keeps the latest best bid and best ask for each stock.
- Coalesces bursts and emits one paced update per stock on the volatility input bus (stock id, best ask, best bid, valid pulse).
- Scheduling is round-robin, so no stock is starved and the downstream pipeline is never overrun.

Parameters:
- DATA_WIDTH, 32, price width.
- NUM_STOCKS, 4, number of tracked stocks; must be a power of 2 and ≥2.
- ISSUE_GAP, 2, minimum idle cycles between consecutive o_data_valid pulses; range 0..15.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_stock_id  in  $clog2(NUM_STOCKS)  stock of incoming update.
- i_data_valid  in  1  incoming update valid, single cycle, no backpressure.
- i_side  in  1  0 = bid update, 1 = ask update.
- i_price  in  DATA_WIDTH  new best price for that side.
- o_stock_id  out  $clog2(NUM_STOCKS)  stock being issued.
- o_best_ask  out  DATA_WIDTH  issued best ask.
- o_best_bid  out  DATA_WIDTH  issued best bid.
- o_data_valid  out  1  one-cycle issue pulse.
- o_pending  out  NUM_STOCKS  per-stock pending bitmap (status).

Behaviour:
- Reset: all book registers 0, all bid/ask seen flags 0, pending 0, RR pointer 0, FSM IDLE, gap counter 0. All outputs 0 in the cycle after reset is sampled. Reset mid-burst discards all pending work; no pulse is emitted afterwards.
- Per stock state: bid, ask, bid_seen, ask_seen, pending.
- Book write, when i_data_valid=1 at edge k:
  - Write i_price into the selected side and set its seen flag.
  - If both seen flags are 1 after the write, and the new bid < new ask (strict, unsigned), set pending for that stock.
  - Crossed or locked book (bid ≥ ask): registers update, pending is not set, and an already-pending stock stays pending.
- Coalescing: further updates to a stock that is already pending only overwrite its registers. Exactly one pulse is issued, carrying the latest values.
- Arbiter:
  - Candidate = first pending stock searching from (last_issued+1) mod NUM_STOCKS upward, with wrap.
  - After reset the search starts at 0.
- FSM:
  - IDLE: if any pending → ISSUE.
  - ISSUE: register o_stock_id, o_best_ask, o_best_bid from the candidate's book, drive o_data_valid=1 for one cycle, and clear that stock's pending. Next state: GAP if ISSUE_GAP>0; otherwise ISSUE if any pending remains, else IDLE.
  - GAP: count ISSUE_GAP cycles, o_data_valid=0. Then go to ISSUE if any pending, else IDLE.
- Latency: an update at edge k (book idle, FSM IDLE) gives o_data_valid high in the cycle after edge k+1, i.e. 2 cycles.
- Simultaneous write and issue to the same stock in one cycle:
  - The issue uses the pre-write values.
  - Pending is cleared by the issue, then set again by the write if the book is valid. The write wins, so a second pulse follows.
- Outside ISSUE, o_stock_id, o_best_ask and o_best_bid hold their last issued values.
- o_pending is a direct view of the pending bits.

Optional Feature:
- Macro: VOLFEED_STATS_EN.
- When defined, adds output o_coalesce_count (32-bit). It increments by 1 on every valid-book update that lands on an already-pending stock and is not cleared in the same cycle. It saturates at all-ones and resets to 0.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Basic issue: reset, then on stock 1 send bid=100, then ask=105 on the next cycle. Expect one pulse 2 cycles after the ask: o_stock_id=1, bid=100, ask=105. o_pending returns to 0.
- Half book / crossed: on stock 2 send only bid=50 → no pulse. Then ask=50 (locked) → no pulse. Then ask=51 → one pulse with 50/51.
- Coalescing: valid book on stock 0 with ISSUE_GAP=2 while stock 3 is issuing. Send bid=10, 11, 12 to stock 0 during the gap. Expect exactly one stock-0 pulse with bid=12; with VOLFEED_STATS_EN, o_coalesce_count=2.
- Round-robin and pacing: make all 4 stocks pending in the same idle window, with the last issue on stock 1. Expect issue order 2, 3, 0, 1, with pulses exactly ISSUE_GAP+1 = 3 cycles apart. Repeat with ISSUE_GAP=0 and expect 4 back-to-back pulses.
- Same-cycle write and issue: stock 0 is pending with bid=20/ask=30. Write bid=25 in the ISSUE cycle. Expect a pulse with 20/30, then a second pulse with 25/30.
- Reset mid-operation: 3 stocks pending, assert i_reset for 1 cycle during GAP. Expect all outputs 0, o_pending=0, and no further pulses until new complete books arrive.
